// File: rtl/seg7_pkg.sv
// Shared definitions for the binary-to-BCD converter and the 7-segment scan path.
package seg7_pkg;

  // Active-low cathode patterns {g,f,e,d,c,b,a} for decimal digits 0..9.
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  // All segments dark / all anodes off.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Double-dabble engine states.
  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } dd_state_t;

  // Smallest digit count whose decimal range covers every WIDTH-bit value.
  function automatic int min_digits(input int width);
    longint max_val;
    longint pow10;
    int     d;
    max_val = (longint'(1) << width) - 1;
    pow10   = 10;
    d       = 1;
    for (int i = 0; i < 20; i++) begin
      if (pow10 <= max_val) begin
        pow10 = pow10 * 10;
        d     = d + 1;
      end
    end
    return d;
  endfunction

  // BCD nibble to active-low segment pattern; non-BCD codes stay dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    logic [6:0] s;
    case (nibble)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/binary2bcd_multidigit_7segment_dd_core.sv
// Iterative shift-add-3 (double-dabble) converter with a latched BCD result.
//
// Handshake: start is a request sampled only in IDLE; the edge that sees
// start=1 in IDLE captures v and enters CONVERT. state==CONVERT is the busy
// indication, and a start seen while converting is dropped (no queueing).
// After WIDTH iterations bcd is written in one shot and done pulses for
// exactly one cycle, during which the engine is already back in IDLE and can
// accept the next start.
module binary2bcd_dd_core
  import seg7_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      v,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output dd_state_t             state
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  dd_state_t         state_next;
  logic [WIDTH-1:0]  bin_work, bin_next;
  logic [BW-1:0]     bcd_work, work_next;
  logic [BW-1:0]     adjusted;
  logic [BW+WIDTH-1:0] shifted;
  logic [CW-1:0]     iter, iter_next;
  logic [BW-1:0]     bcd_next;
  logic              done_next;

  // Next-state, one double-dabble step and result latch.
  always_comb begin
    state_next = state;
    bin_next   = bin_work;
    work_next  = bcd_work;
    iter_next  = iter;
    bcd_next   = bcd;
    done_next  = 1'b0;

    adjusted = bcd_work;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_work[4*i +: 4] >= 4'd5) begin
        adjusted[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
      end
    end
    shifted = {adjusted, bin_work} << 1;

    case (state)
      IDLE: begin
        if (start) begin
          state_next = CONVERT;
          bin_next   = v;
          work_next  = '0;
          iter_next  = '0;
        end
      end
      CONVERT: begin
        bin_next  = shifted[WIDTH-1:0];
        work_next = shifted[BW+WIDTH-1 -: BW];
        iter_next = iter + CW'(1);
        if (iter == CW'(WIDTH - 1)) begin
          state_next = IDLE;
          bcd_next   = shifted[BW+WIDTH-1 -: BW];
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bin_work <= '0;
      bcd_work <= '0;
      iter     <= '0;
      bcd      <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      bin_work <= bin_next;
      bcd_work <= work_next;
      iter     <= iter_next;
      bcd      <= bcd_next;
      done     <= done_next;
    end
  end

endmodule

// File: rtl/binary2bcd_multidigit_7segment.sv
// Binary to multi-digit BCD conversion and time-multiplexed drive of an
// 8-digit common-anode 7-segment display with optional leading-zero blanking.
module binary2bcd_multidigit_7segment
  import seg7_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int DIGITS        = 5,
  parameter int REFRESH_DIV   = 50000,
  parameter int BLANK_LEADING = 1
) (
  input  logic                Clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WIDTH-1:0]    v,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic [7:0]          an,
  output logic [6:0]          seg
);

  localparam int RW = $clog2(REFRESH_DIV);

  // Reject configurations the display or the digit count cannot represent.
  generate
    if (WIDTH < 1 || WIDTH > 26) begin : g_bad_width
      $error("WIDTH must be in 1..26");
    end
    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
      $error("DIGITS must be in 1..8");
    end
    if (REFRESH_DIV < 2) begin : g_bad_refresh
      $error("REFRESH_DIV must be at least 2");
    end
    if (DIGITS < min_digits(WIDTH)) begin : g_too_few_digits
      $error("DIGITS too small to hold the largest WIDTH-bit value");
    end
  endgenerate

  dd_state_t dd_state;

  binary2bcd_dd_core #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_core (
    .clk   (Clk),
    .reset (reset),
    .start (start),
    .v     (v),
    .done  (done),
    .bcd   (bcd),
    .state (dd_state)
  );

  assign busy = (dd_state == CONVERT);

  logic [RW-1:0]     refresh_cnt;
  logic [2:0]        idx;
  logic [DIGITS-1:0] blank;
  logic [3:0]        digit_sel;
  logic              blank_sel;
  logic [7:0]        an_next;
  logic [6:0]        seg_next;

  // Blank mask, digit select and the anode/cathode pattern for the current slot.
  always_comb begin
    logic upper_nz;
    upper_nz = 1'b0;
    blank    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_nz = upper_nz | (bcd[4*i +: 4] != 4'd0);
      blank[i] = (BLANK_LEADING != 0) && (i != 0) && !upper_nz;
    end

    digit_sel = 4'd0;
    blank_sel = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == 3'(i)) begin
        digit_sel = bcd[4*i +: 4];
        blank_sel = blank[i];
      end
    end

    an_next  = AN_OFF;
    seg_next = SEG_BLANK;
    if (!blank_sel) begin
      an_next[idx] = 1'b0;
      seg_next     = seg_decode(digit_sel);
    end
  end

  // Refresh divider, digit index and registered display outputs.
  always_ff @(posedge Clk) begin
    if (reset) begin
      refresh_cnt <= '0;
      idx         <= 3'd0;
      an          <= AN_OFF;
      seg         <= SEG_BLANK;
    end else begin
      if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
        refresh_cnt <= '0;
        idx         <= (idx == 3'(DIGITS - 1)) ? 3'd0 : idx + 3'd1;
      end else begin
        refresh_cnt <= refresh_cnt + RW'(1);
      end
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_binary2bcd_multidigit_7segment.sv
// Bench for binary2bcd_multidigit_7segment: three configurations sharing one
// clock and reset, a BCD scoreboard, and an arithmetic display model.
module tb_binary2bcd_multidigit_7segment;

  localparam int RD = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start, start_c;
  logic [15:0] v;
  logic [3:0]  v_c;

  logic        busy_a, done_a, busy_b, done_b, busy_c, done_c;
  logic [19:0] bcd_a, bcd_b;
  logic [7:0]  bcd_c;
  logic [7:0]  an_a, an_b, an_c;
  logic [6:0]  seg_a, seg_b, seg_c;

  binary2bcd_multidigit_7segment #(.WIDTH(16), .DIGITS(5), .REFRESH_DIV(RD), .BLANK_LEADING(1)) dut_a (
    .Clk(clk), .reset(reset), .start(start), .v(v),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .an(an_a), .seg(seg_a));

  binary2bcd_multidigit_7segment #(.WIDTH(16), .DIGITS(5), .REFRESH_DIV(RD), .BLANK_LEADING(0)) dut_b (
    .Clk(clk), .reset(reset), .start(start), .v(v),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .an(an_b), .seg(seg_b));

  binary2bcd_multidigit_7segment #(.WIDTH(4), .DIGITS(2), .REFRESH_DIV(RD), .BLANK_LEADING(1)) dut_c (
    .Clk(clk), .reset(reset), .start(start_c), .v(v_c),
    .busy(busy_c), .done(done_c), .bcd(bcd_c), .an(an_c), .seg(seg_c));

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int done_seen_a = 0, done_seen_b = 0, done_seen_c = 0;
  int k_edges = 0;
  int shown_ab = 0;
  int shown_c  = 0;
  logic [19:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
  endtask

  // Edges since reset was last sampled low.
  always @(posedge clk) begin
    if (reset) k_edges <= 0;
    else       k_edges <= k_edges + 1;
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_bcd(input int value, input int digits);
    logic [31:0] r;
    int x;
    r = '0;
    x = value;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  // Slot i shows decimal digit i of value, dark if blanking and value < 10^i.
  task automatic ref_display(input int value, input int blank_en, input int slot,
                             output logic [7:0] ean, output logic [6:0] eseg);
    int p;
    p = 1;
    for (int i = 0; i < slot; i++) p = p * 10;
    if (blank_en != 0 && slot > 0 && value < p) begin
      ean  = 8'hFF;
      eseg = 7'h7F;
    end else begin
      ean  = ~(8'd1 << slot);
      eseg = ref_seg((value / p) % 10);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (done_b) done_seen_b++;
    if (done_c) done_seen_c++;
    if (done_a) begin
      done_seen_a++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done_a), 32'(0));
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        check("sb_bcd_a", 32'(bcd_a), 32'(e));
        check("sb_bcd_b", 32'(bcd_b), 32'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_scan(input int cycles);
    logic [7:0] ean;
    logic [6:0] eseg;
    int slot5, slot2;
    repeat (cycles) begin
      @(negedge clk);
      slot5 = ((k_edges - 1) / RD) % 5;
      slot2 = ((k_edges - 1) / RD) % 2;
      ref_display(shown_ab, 1, slot5, ean, eseg);
      check("scan_a_an", 32'(an_a), 32'(ean));
      check("scan_a_seg", 32'(seg_a), 32'(eseg));
      ref_display(shown_ab, 0, slot5, ean, eseg);
      check("scan_b_an", 32'(an_b), 32'(ean));
      check("scan_b_seg", 32'(seg_b), 32'(eseg));
      ref_display(shown_c, 1, slot2, ean, eseg);
      check("scan_c_an", 32'(an_c), 32'(ean));
      check("scan_c_seg", 32'(seg_c), 32'(eseg));
    end
  endtask

  task automatic wait_done_a(input int bound);
    bit ok;
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done_a) begin
        ok = 1;
        break;
      end
    end
    check("done_timeout", 32'(ok), 32'(1));
  endtask

  task automatic run_convert_a(input logic [15:0] val, input logic [19:0] expv);
    @(negedge clk);
    start = 1'b1;
    v     = val;
    exp_q.push_back(expv);
    @(negedge clk);
    start = 1'b0;
    v     = 16'($urandom_range(65535));
    check("busy_after_start", 32'(busy_a), 32'(1));
    check("done_low_early", 32'(done_a), 32'(0));
    repeat (15) @(negedge clk);
    check("busy_last_iter", 32'(busy_a), 32'(1));
    check("done_last_iter", 32'(done_a), 32'(0));
    @(negedge clk);
    check("done_pulse", 32'(done_a), 32'(1));
    check("busy_end", 32'(busy_a), 32'(0));
    check("bcd_latency", 32'(bcd_a), 32'(expv));
    @(negedge clk);
    check("done_drop", 32'(done_a), 32'(0));
    shown_ab = int'(val);
    @(negedge clk);
  endtask

  task automatic run_convert_c(input logic [3:0] val, input logic [7:0] expv);
    @(negedge clk);
    start_c = 1'b1;
    v_c     = val;
    @(negedge clk);
    start_c = 1'b0;
    v_c     = 4'($urandom_range(15));
    repeat (3) @(negedge clk);
    check("c_busy_last_iter", 32'(busy_c), 32'(1));
    check("c_done_early", 32'(done_c), 32'(0));
    @(negedge clk);
    check("c_done_pulse", 32'(done_c), 32'(1));
    check("c_bcd", 32'(bcd_c), 32'(expv));
    @(negedge clk);
    shown_c = int'(val);
    @(negedge clk);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [15:0] val;
    logic [19:0] expv;
  } vec_a_t;

  typedef struct {
    logic [3:0] val;
    logic [7:0] expv;
  } vec_c_t;

  vec_a_t tab_a[6];
  vec_c_t tab_c[6];

  // ---------------- main sequence ----------------
  initial begin
    int d0;
    logic [15:0] rv;

    tab_a[0] = '{16'd65535, 20'h65535};
    tab_a[1] = '{16'd42,    20'h00042};
    tab_a[2] = '{16'd0,     20'h00000};
    tab_a[3] = '{16'd10000, 20'h10000};
    tab_a[4] = '{16'd9,     20'h00009};
    tab_a[5] = '{16'd100,   20'h00100};

    tab_c[0] = '{4'd13, 8'h13};
    tab_c[1] = '{4'd9,  8'h09};
    tab_c[2] = '{4'd0,  8'h00};
    tab_c[3] = '{4'd15, 8'h15};
    tab_c[4] = '{4'd10, 8'h10};
    tab_c[5] = '{4'd7,  8'h07};

    reset = 1'b1; start = 1'b0; v = '0; start_c = 1'b0; v_c = '0;

    // Reset for 3 cycles: display dark, handshake idle.
    repeat (3) begin
      @(negedge clk);
      check("rst_an_a", 32'(an_a), 32'(8'hFF));
      check("rst_seg_a", 32'(seg_a), 32'(7'h7F));
      check("rst_an_c", 32'(an_c), 32'(8'hFF));
      check("rst_busy", 32'(busy_a), 32'(0));
      check("rst_done", 32'(done_a), 32'(0));
      check("rst_bcd", 32'(bcd_a), 32'(0));
    end
    reset = 1'b0;
    check_scan(40);

    // Table-driven conversions with display scans.
    for (int i = 0; i < 6; i++) begin
      run_convert_a(tab_a[i].val, tab_a[i].expv);
      check_scan(20);
    end

    // Randomised conversions against the arithmetic model.
    for (int i = 0; i < 12; i++) begin
      rv = 16'($urandom_range(65535));
      run_convert_a(rv, ref_bcd(int'(rv), 5)[19:0]);
      if (i < 3) check_scan(20);
    end

    // Start while busy is ignored; start in the done cycle is accepted.
    d0 = done_seen_a;
    @(negedge clk);
    start = 1'b1; v = 16'd1234;
    exp_q.push_back(20'h01234);
    for (int c = 1; c < 16; c++) begin
      @(negedge clk);
      start = (c == 3);
      v     = (c == 3) ? 16'd9999 : 16'($urandom_range(65535));
    end
    @(negedge clk);
    start = 1'b0;
    v     = 16'($urandom_range(65535));
    @(negedge clk);
    check("mid_done", 32'(done_a), 32'(1));
    check("mid_bcd", 32'(bcd_a), 32'(20'h01234));
    start = 1'b1; v = 16'd9999;
    exp_q.push_back(20'h09999);
    @(negedge clk);
    start = 1'b0;
    check("done_cycle_start_busy", 32'(busy_a), 32'(1));
    check("done_cycle_start_done", 32'(done_a), 32'(0));
    wait_done_a(40);
    @(negedge clk);
    check("mid_bcd2", 32'(bcd_a), 32'(20'h09999));
    check("mid_done_count", 32'(done_seen_a - d0), 32'(2));
    shown_ab = 9999;
    check_scan(20);

    // Reset in CONVERT cycle 5 aborts the conversion.
    d0 = done_seen_a;
    @(negedge clk);
    start = 1'b1; v = 16'd54321;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy_a), 32'(0));
    check("abort_done", 32'(done_a), 32'(0));
    check("abort_bcd", 32'(bcd_a), 32'(0));
    check("abort_an", 32'(an_a), 32'(8'hFF));
    check("abort_seg", 32'(seg_a), 32'(7'h7F));
    reset = 1'b0;
    shown_ab = 0;
    shown_c  = 0;
    check_scan(40);
    check("abort_no_done", 32'(done_seen_a - d0), 32'(0));

    // Previous-generation configuration.
    d0 = done_seen_c;
    for (int i = 0; i < 6; i++) begin
      run_convert_c(tab_c[i].val, tab_c[i].expv);
      check_scan(16);
    end
    check("c_done_count", 32'(done_seen_c - d0), 32'(6));

    check("queue_empty", 32'(exp_q.size()), 32'(0));
    check("done_a_eq_b", 32'(done_seen_b), 32'(done_seen_a));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
